// File: rtl/toggle_cover_collector.sv
// Toggle-coverage collector: sticky per-point bitmap, drained lowest-index-first as global indices.
// Optional macro TOGGLE_RISE_FALL_EN gives every probe bit separate rise and fall points.
module toggle_cover_collector #(
    parameter int          WIDTH       = 5,
    parameter logic [63:0] COVER_INDEX = 64'd0,
    parameter int          INDEX_W     = 64,
`ifdef TOGGLE_RISE_FALL_EN
    localparam int         POINTS      = 2 * WIDTH,
`else
    localparam int         POINTS      = WIDTH,
`endif
    localparam int         CNT_W       = $clog2(POINTS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   probe,
    input  logic               clear,
    output logic               cover_valid,
    input  logic               cover_ready,
    output logic [INDEX_W-1:0] cover_index,
    output logic [CNT_W-1:0]   hit_count,
    output logic               all_hit
);

    logic [WIDTH-1:0]  prev_p0;
    logic              base_ok_p0;
    logic [POINTS-1:0] covered_p0;
    logic [POINTS-1:0] pending_p0;

    logic [WIDTH-1:0]  toggled;
    logic [POINTS-1:0] event_pts;
    logic [POINTS-1:0] new_hits;
    logic              load_en;
    logic              grant_vld;
    logic [31:0]       grant_idx;
    logic [POINTS-1:0] grant_mask;

    function automatic logic [CNT_W-1:0] popcount(input logic [POINTS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < POINTS; i++)
            n = n + CNT_W'(v[i]);
        return n;
    endfunction

    function automatic logic [31:0] lowest_set(input logic [POINTS-1:0] v);
        logic [31:0] idx;
        idx = '0;
        for (int i = POINTS - 1; i >= 0; i--)
            if (v[i]) idx = 32'(i);
        return idx;
    endfunction

    // Wraps modulo 2^INDEX_W by construction.
    function automatic logic [INDEX_W-1:0] global_index(input logic [31:0] local_idx);
        return INDEX_W'(COVER_INDEX) + INDEX_W'(local_idx);
    endfunction

    assign toggled = base_ok_p0 ? (probe ^ prev_p0) : '0;

`ifdef TOGGLE_RISE_FALL_EN
    assign event_pts = {toggled & ~probe, toggled & probe};
`else
    assign event_pts = toggled;
`endif

    assign new_hits  = event_pts & ~covered_p0;
    assign load_en   = !cover_valid || cover_ready;
    assign grant_vld = |pending_p0;
    assign grant_idx = lowest_set(pending_p0);
    // The arbiter only ever sees pending from before this edge's new hits.
    assign grant_mask = (load_en && grant_vld) ? (POINTS'(1) << grant_idx) : '0;

    // Stage 0: baseline, sticky coverage and pending bookkeeping
    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_p0    <= '0;
            base_ok_p0 <= 1'b0;
            covered_p0 <= '0;
            pending_p0 <= '0;
            hit_count  <= '0;
        end else begin
            prev_p0    <= probe;
            base_ok_p0 <= 1'b1;
            if (clear) begin
                covered_p0 <= '0;
                pending_p0 <= '0;
                hit_count  <= '0;
            end else begin
                covered_p0 <= covered_p0 | new_hits;
                pending_p0 <= (pending_p0 & ~grant_mask) | new_hits;
                hit_count  <= hit_count + popcount(new_hits);
            end
        end
    end

    // Stage 1: output beat register
    always_ff @(posedge clock) begin
        if (!reset) begin
            cover_valid <= 1'b0;
            cover_index <= '0;
        end else if (clear) begin
            cover_valid <= 1'b0;
        end else if (load_en) begin
            cover_valid <= grant_vld;
            if (grant_vld)
                cover_index <= global_index(grant_idx);
        end
    end

    assign all_hit = (hit_count == CNT_W'(POINTS));

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Scoreboard bench for toggle_cover_collector: a main instance (base 100) and a narrow wrapping instance (base 254).
module tb_toggle_cover_collector;

    localparam int WIDTH = 5;
`ifdef TOGGLE_RISE_FALL_EN
    localparam int NP = 2 * WIDTH;
    localparam int HC_BIT2 = 2;
    localparam int ALL_AT5 = 0;
`else
    localparam int NP = WIDTH;
    localparam int HC_BIT2 = 1;
    localparam int ALL_AT5 = 1;
`endif
    localparam int CW = $clog2(NP + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic             cover_ready = 1'b1;
    logic [WIDTH-1:0] probe = '0;

    logic             v0, ah0, v1, ah1;
    logic [63:0]      idx0;
    logic [7:0]       idx1;
    logic [CW-1:0]    hc0, hc1;

    int checks = 0;
    int errors = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    bit               m_cov[2][NP];
    bit               m_pend[2][NP];
    logic [WIDTH-1:0] m_prev[2];
    bit               m_base[2];
    bit               m_valid[2];
    int               m_cnt[2];

    toggle_cover_collector #(.WIDTH(WIDTH), .COVER_INDEX(64'd100), .INDEX_W(64)) dut_main (
        .clock(clock), .reset(reset), .probe(probe), .clear(clear),
        .cover_valid(v0), .cover_ready(cover_ready), .cover_index(idx0),
        .hit_count(hc0), .all_hit(ah0)
    );

    toggle_cover_collector #(.WIDTH(WIDTH), .COVER_INDEX(64'd254), .INDEX_W(8)) dut_wrap (
        .clock(clock), .reset(reset), .probe(probe), .clear(clear),
        .cover_valid(v1), .cover_ready(1'b1), .cover_index(idx1),
        .hit_count(hc1), .all_hit(ah1)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_index(input int k, input int p);
        if (k == 0) return 64'(100 + p);
        return 64'((254 + p) % 256);
    endfunction

    // Reference model: one call per clock edge, using the inputs present at that edge.
    task automatic model_step(input int k, input bit rdy);
        int p;
        int pt;
        if (!reset || clear) begin
            for (int i = 0; i < NP; i++) begin
                m_cov[k][i]  = 1'b0;
                m_pend[k][i] = 1'b0;
            end
            m_cnt[k]   = 0;
            m_valid[k] = 1'b0;
            if (k == 0) q0.delete(); else q1.delete();
            if (!reset) begin
                m_prev[k] = '0;
                m_base[k] = 1'b0;
                return;
            end
        end else begin
            if (!m_valid[k] || rdy) begin
                p = -1;
                for (int i = NP - 1; i >= 0; i--)
                    if (m_pend[k][i]) p = i;
                m_valid[k] = (p >= 0);
                if (p >= 0) begin
                    m_pend[k][p] = 1'b0;
                    if (k == 0) q0.push_back(exp_index(k, p));
                    else        q1.push_back(exp_index(k, p));
                end
            end
            if (m_base[k]) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (probe[i] != m_prev[k][i]) begin
                        pt = i;
`ifdef TOGGLE_RISE_FALL_EN
                        if (!probe[i]) pt = WIDTH + i;
`endif
                        if (!m_cov[k][pt]) begin
                            m_cov[k][pt]  = 1'b1;
                            m_pend[k][pt] = 1'b1;
                            m_cnt[k]++;
                        end
                    end
                end
            end
        end
        m_prev[k] = probe;
        m_base[k] = 1'b1;
    endtask

    always @(posedge clock) begin
        model_step(0, cover_ready);
        model_step(1, 1'b1);
    end

    task automatic mon(input int k, input logic v, input logic [63:0] idx,
                       input logic [CW-1:0] hc, input logic ah, input bit rdy);
        logic [63:0] e;
        check($sformatf("valid%0d", k), 64'(v), 64'(m_valid[k]));
        if (m_valid[k]) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL queue%0d: got empty scoreboard, expected an index", k);
            end else begin
                e = (k == 0) ? q0[0] : q1[0];
                check($sformatf("index%0d", k), idx, e);
                if (rdy) begin
                    if (k == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end
        check($sformatf("hit_count%0d", k), 64'(hc), 64'(m_cnt[k]));
        check($sformatf("all_hit%0d", k), 64'(ah), 64'(m_cnt[k] == NP));
    endtask

    always @(negedge clock) begin
        mon(0, v0, idx0, hc0, ah0, cover_ready);
        mon(1, v1, {56'd0, idx1}, hc1, ah1, 1'b1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            step(1);
            probe = ~probe;
        end
        check("reset_valid", 64'(v0), 64'd0);
        check("reset_index", idx0, 64'd0);
        check("reset_hits", 64'(hc0), 64'd0);

        reset = 1'b1;
        probe = '0;
        step(1);
        check("release_valid", 64'(v0), 64'd0);
        step(1);

        probe = 5'b00100;
        step(1);
        check("bit2_hits", 64'(hc0), 64'd1);
        step(1);
        check("bit2_valid", 64'(v0), 64'd1);
        check("bit2_index", idx0, 64'd102);

        for (int i = 0; i < 20; i++) begin
            probe = probe ^ 5'b00100;
            step(1);
        end
        check("bit2_repeat_hits", 64'(hc0), 64'(HC_BIT2));
        step(3);

        clear = 1'b1;
        probe = '0;
        step(1);
        clear = 1'b0;
        check("clear1_hits", 64'(hc0), 64'd0);
        step(2);

        cover_ready = 1'b0;
        probe = '1;
        step(1);
        check("burst_hits", 64'(hc0), 64'd5);
        check("burst_all_hit", 64'(ah0), 64'(ALL_AT5));
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("bp_valid", 64'(v0), 64'd1);
            check("bp_index", idx0, 64'd100);
        end
        check("wrap_index", {56'd0, idx1}, 64'd1);
        cover_ready = 1'b1;
        for (int p = 1; p < 5; p++) begin
            step(1);
            check("drain_index", idx0, 64'(100 + p));
        end
        step(2);

        probe = probe ^ 5'b00001;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear2_hits", 64'(hc0), 64'd0);
        check("clear2_valid", 64'(v0), 64'd0);
        probe = probe ^ 5'b00001;
        step(2);
        check("after_clear_valid", 64'(v0), 64'd1);
        check("after_clear_index", idx0, 64'd100);

        for (int c = 0; c < 800; c++) begin
            cover_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 2) == 0)
                probe = probe ^ WIDTH'($urandom_range(0, 31));
            step(1);
        end

        reset = 1'b1;
        clear = 1'b0;
        cover_ready = 1'b1;
        step(NP + 4);
        check("final_q0", 64'(q0.size()), 64'd0);
        check("final_q1", 64'(q1.size()), 64'd0);
        check("final_valid", 64'(v0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_cover_collector.md
# toggle_cover_collector

Parametrised toggle-coverage collector for the fuzzing/formal harness: watches a WIDTH-bit probe vector, detects bit transitions, records each toggle point once in a sticky bitmap and drains newly covered points as indices over a valid/ready stream. It is the hardware-side successor of the per-cycle toggle reporters. Each point is reported once per clear rather than on every active cycle, with lowest-index-first arbitration and a live hit count. It sits beside each instrumented signal group and feeds the coverage aggregator.

## Interface
- WIDTH, 5: number of probed bits.
- COVER_INDEX, 0: global index of this instance's first point.
- INDEX_W, 64: width of cover_index.
- POINTS (localparam): WIDTH, or 2*WIDTH with TOGGLE_RISE_FALL_EN.
- CNT_W (localparam): $clog2(POINTS+1).

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- probe  in  WIDTH  monitored signals.
- clear  in  1  synchronous coverage clear (active-high).
- cover_valid  out  1  a newly covered point index is presented.
- cover_ready  in  1  consumer accepts cover_index.
- cover_index  out  INDEX_W  global point index, COVER_INDEX + local index.
- hit_count  out  CNT_W  number of covered points.
- all_hit  out  1  hit_count == POINTS.

## Operation
- State: prev[WIDTH], base_ok flag, covered[POINTS], pending[POINTS], output register (cover_valid, cover_index).
- Baseline: the first edge after reset release or enable loads prev and sets base_ok. No event is detected while base_ok = 0.
- Event on bit i when base_ok and probe[i] != prev[i]; prev <= probe every cycle.
- Point mapping (no macro): any transition on bit i maps to local point i.
- New hit: event on a point with covered = 0. That edge sets covered and pending and increments hit_count. Repeat events on covered points are ignored.
- Several points may hit in one cycle. hit_count then adds the popcount of new hits that cycle.
- Output register loads when empty or when the current beat is accepted (cover_valid & cover_ready). It takes the lowest set pending bit and clears that pending bit on load.
- Handshake: while cover_valid=1 and cover_ready=0, cover_index is held stable and cover_valid stays high.
- clear=1: covered, pending, hit_count and cover_valid are zeroed. Events in the same cycle are discarded. prev still updates and base_ok is unchanged (no re-baseline).
- Reset: all outputs 0 (cover_valid=0, cover_index=0, hit_count=0, all_hit=0); prev, covered, pending cleared; base_ok=0. Reset overrides clear.
- cover_index arithmetic: zero-extend the local index to INDEX_W, then add COVER_INDEX. The sum wraps modulo 2^INDEX_W.

## Timing
- Probe change sampled at edge N: pending and hit_count update at edge N. cover_valid rises at edge N+1 if the output register is free. Detection-to-report latency is 1 cycle.
- Throughput: one index per cycle with cover_ready held high.
- all_hit is combinational from hit_count.
- If a new hit and an accepted beat occur in the same cycle, both take effect. The arbiter sees pending as it was before that edge's new hits, so a point hit at edge N is never presented before edge N+1.

## Configuration
- TOGGLE_RISE_FALL_EN defined:
  - POINTS = 2*WIDTH.
  - A 0->1 transition on bit i maps to local point i.
  - A 1->0 transition on bit i maps to local point WIDTH+i.
  - all_hit needs both directions on every bit.
- TOGGLE_RISE_FALL_EN undefined:
  - POINTS = WIDTH.
  - Either direction maps to local point i.

## Test plan
(WIDTH=5, COVER_INDEX=100, cover_ready=1 unless stated.)
- Reset: hold reset=0 for 3 cycles with a probe toggling every cycle. Required: all outputs 0, no cover_valid for one cycle after release.
- Single and repeat toggle: baseline probe=5'b00000, then set bit 2 → one beat cover_index=102, hit_count=1. Toggle bit 2 back and forth 10 times → no further beats, hit_count stays 1.
- Simultaneous hits under backpressure: probe 00000→11111 with cover_ready=0 for 4 cycles. Required: cover_valid held at index 100 for the 4 cycles, hit_count=5 and all_hit=1 immediately. After ready rises, beats 100,101,102,103,104 on consecutive cycles.
- Clear: after full coverage, pulse clear for 1 cycle while bit 0 toggles. Required: hit_count=0, cover_valid=0, the same-cycle toggle is not counted; the next toggle of bit 0 reports 100.
- TOGGLE_RISE_FALL_EN: bit 3 rises then falls. Required: beats 103 then 108, hit_count=2, all_hit=0.
- Index wrap: INDEX_W=8, COVER_INDEX=254, toggle bit 3 → cover_index=1.
